ram_read_checker: RTL and testbench

RAM_READ_CHECKER -- requirements
Module: ram_read_checker

---
 rtl/ram_test_pkg.sv | 23 ++
 rtl/ram_rd_pipe.sv | 39 +++
 rtl/ram_read_checker.sv | 151 +++++++++++++++
 tb/tb_ram_read_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM readback checker: FSM encoding and
// the supported range of RAM read latency.
package ram_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Keeps an out-of-range latency parameter inside the supported window
   // so the delay line and drain counter are always sized sensibly.
   function automatic int clamp_rd_lat(input int lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line that carries an issued read address and its valid bit
// forward by the RAM read latency, so the checker sees the address that
// belongs to the data currently on the RAM output.
module ram_rd_pipe #(
   parameter int WIDTH  = 9,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [RD_LAT-1:0] vld_q;
   logic [WIDTH-1:0]  dat_q [RD_LAT];

   // Shift valid and address one stage per clock; reset empties the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         dat_q[0] <= in_data;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[RD_LAT-1];
   assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_read_checker.sv
// Reads every word of a RAM once per pass and checks it against the
// pattern (address + SEED), counting mismatches and recording the first.
module ram_read_checker
   import ram_test_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1,
   parameter int SEED   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data
);

   localparam int                LAT        = clamp_rd_lat(RD_LAT);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
   localparam logic [ADDR_W:0]   ERR_SAT    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [1:0]        DRAIN_LAST = 2'(LAT - 1);
   localparam logic [DATA_W-1:0] SEED_W     = DATA_W'(SEED);

   state_t              state_q;
   state_t              state_d;
   logic                start_ok;
   logic [1:0]          drain_q;
   logic                chk_valid;
   logic [ADDR_W-1:0]   chk_addr;
   logic [DATA_W-1:0]   exp_data;
   logic                mismatch;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and state-decoded outputs; start only counts when idle or done.
   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      rd_en    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = READ;
            end
         end
         READ: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (rd_addr == ADDR_LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_q == DRAIN_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               start_ok = 1'b1;
               state_d  = READ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pass = done && (err_cnt == '0);

   // Address counter: restarts at 0 on a new pass and parks on the last
   // address so it never wraps inside a pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr <= '0;
      end else if (start_ok) begin
         rd_addr <= '0;
      end else if (state_q == READ && rd_addr != ADDR_LAST) begin
         rd_addr <= rd_addr + 1'b1;
      end
   end

   // Drain counter: counts the cycles spent waiting for in-flight reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_q <= '0;
      end else if (state_q == DRAIN) begin
         drain_q <= drain_q + 1'b1;
      end else begin
         drain_q <= '0;
      end
   end

   ram_rd_pipe #(
      .WIDTH  (ADDR_W),
      .RD_LAT (LAT)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_en),
      .in_data   (rd_addr),
      .out_valid (chk_valid),
      .out_data  (chk_addr)
   );

   assign exp_data = DATA_W'(chk_addr) + SEED_W;
   assign mismatch = chk_valid && (rd_data != exp_data);

   // Error bookkeeping: cleared on each accepted start; the first mismatch
   // of a pass is the one seen while the count is still zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (start_ok) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (mismatch) begin
         if (err_cnt == '0) begin
            first_err_addr <= chk_addr;
            first_err_data <= rd_data;
         end
         if (err_cnt != ERR_SAT) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_read_checker.sv
// Scoreboard bench for ram_read_checker: three instances (latency 1,
// latency 2, seed 0) share one RAM model; expected pass results are queued
// at start and checked by a monitor when done rises.
module tb_ram_read_checker;

   localparam int AW = 9;
   localparam int DW = 16;

   typedef struct {
      int            id;
      logic [AW:0]   err;
      logic [AW-1:0] fea;
      logic [DW-1:0] fed;
      logic          pss;
      int            busy_cycles;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_v  [3];
   logic [AW-1:0] addr_v   [3];
   logic          rd_en_v  [3];
   logic [DW-1:0] rdat     [3];
   logic          busy_v   [3];
   logic          done_v   [3];
   logic          pass_v   [3];
   logic [AW:0]   err_v    [3];
   logic [AW-1:0] fea_v    [3];
   logic [DW-1:0] fed_v    [3];
   logic [DW-1:0] p2;
   logic [DW-1:0] mem      [512];

   exp_t sb_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   busy_cnt  [3];
   logic busy_prev [3];
   logic done_prev [3];

   always #5 clk = ~clk;

   ram_read_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .SEED(1)) dut_lat1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rd_addr(addr_v[0]), .rd_en(rd_en_v[0]),
      .rd_data(rdat[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_cnt(err_v[0]), .first_err_addr(fea_v[0]), .first_err_data(fed_v[0]));

   ram_read_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .SEED(1)) dut_lat2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rd_addr(addr_v[1]), .rd_en(rd_en_v[1]),
      .rd_data(rdat[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_cnt(err_v[1]), .first_err_addr(fea_v[1]), .first_err_data(fed_v[1]));

   ram_read_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .SEED(0)) dut_seed0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .rd_addr(addr_v[2]), .rd_en(rd_en_v[2]),
      .rd_data(rdat[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_cnt(err_v[2]), .first_err_addr(fea_v[2]), .first_err_data(fed_v[2]));

   // RAM model read ports: one register stage for latency 1, two for latency 2.
   always @(posedge clk) begin
      rdat[0] <= mem[addr_v[0]];
      p2      <= mem[addr_v[1]];
      rdat[1] <= p2;
      rdat[2] <= mem[addr_v[2]];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles per instance and scores each pass on done.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy_v[i] && !busy_prev[i]) busy_cnt[i] = 1;
         else if (busy_v[i]) busy_cnt[i]++;
         if (done_v[i] && !done_prev[i]) begin
            if (sb_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_done: got done on dut %0d expected none", i);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_output("dut_id", 32'(i), 32'(e.id));
               check_output("err_cnt", 32'(err_v[i]), 32'(e.err));
               check_output("first_err_addr", 32'(fea_v[i]), 32'(e.fea));
               check_output("first_err_data", 32'(fed_v[i]), 32'(e.fed));
               check_output("pass", 32'(pass_v[i]), 32'(e.pss));
               check_output("busy_cycles", 32'(busy_cnt[i]), 32'(e.busy_cycles));
            end
         end
         busy_prev[i] = busy_v[i];
         done_prev[i] = done_v[i];
      end
   end

   task automatic pulse_start(input int id);
      @(posedge clk);
      #1 start_v[id] = 1'b1;
      @(posedge clk);
      #1 start_v[id] = 1'b0;
   endtask

   task automatic apply_stimulus(input int id, input logic [AW:0] err, input logic [AW-1:0] fea,
                                 input logic [DW-1:0] fed, input logic pss, input int bc);
      exp_t e;
      e.id = id; e.err = err; e.fea = fea; e.fed = fed; e.pss = pss; e.busy_cycles = bc;
      sb_q.push_back(e);
      pulse_start(id);
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL done_timeout: got %0d pending results expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic fill_mem();
      for (int a = 0; a < 512; a++) mem[a] = 16'(a + 1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; busy_cnt[i] = 0; busy_prev[i] = 1'b0; done_prev[i] = 1'b0;
      end
      fill_mem();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_output($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
         check_output($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
         check_output($sformatf("rst_rd_en%0d", i), 32'(rd_en_v[i]), 32'd0);
         check_output($sformatf("rst_err%0d", i), 32'(err_v[i]), 32'd0);
      end

      // Clean pass at latency 1.
      apply_stimulus(0, 10'd0, 9'h000, 16'h0000, 1'b1, 513);
      wait_drain(2000);

      // Single corrupted word.
      mem[9'h05A] = 16'hFFFF;
      apply_stimulus(0, 10'd1, 9'h05A, 16'hFFFF, 1'b0, 513);
      wait_drain(2000);
      fill_mem();

      // Two corrupted words at latency 2, including the last address.
      mem[9'h010] = 16'hAAAA;
      mem[9'h1FF] = 16'h0000;
      apply_stimulus(1, 10'd2, 9'h010, 16'hAAAA, 1'b0, 514);
      wait_drain(2000);
      fill_mem();

      // Restart while busy is ignored; restart from done clears the results.
      mem[9'h05A] = 16'hFFFF;
      apply_stimulus(0, 10'd1, 9'h05A, 16'hFFFF, 1'b0, 513);
      repeat (99) @(posedge clk);
      pulse_start(0);
      wait_drain(2000);
      fill_mem();
      apply_stimulus(0, 10'd0, 9'h000, 16'h0000, 1'b1, 513);
      wait_drain(2000);

      // Reset in the middle of a pass.
      mem[9'h05A] = 16'hFFFF;
      pulse_start(0);
      repeat (199) @(posedge clk);
      #1;
      check_output("pre_reset_err", 32'(err_v[0]), 32'd1);
      check_output("pre_reset_busy", 32'(busy_v[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_rd_addr", 32'(addr_v[0]), 32'd0);
      check_output("mid_rst_rd_en", 32'(rd_en_v[0]), 32'd0);
      check_output("mid_rst_busy", 32'(busy_v[0]), 32'd0);
      check_output("mid_rst_done", 32'(done_v[0]), 32'd0);
      check_output("mid_rst_pass", 32'(pass_v[0]), 32'd0);
      check_output("mid_rst_err", 32'(err_v[0]), 32'd0);
      check_output("mid_rst_fea", 32'(fea_v[0]), 32'd0);
      check_output("mid_rst_fed", 32'(fed_v[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fill_mem();
      repeat (600) @(posedge clk);
      #1;
      check_output("post_rst_done", 32'(done_v[0]), 32'd0);
      check_output("post_rst_busy", 32'(busy_v[0]), 32'd0);
      check_output("post_rst_rd_en", 32'(rd_en_v[0]), 32'd0);

      // Every word wrong against a zero seed.
      apply_stimulus(2, 10'd512, 9'h000, 16'h0001, 1'b0, 513);
      wait_drain(2000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
